// File: rtl/voice_mixer.sv
// Frame-rate voice mixer: snapshots the generator bank once per audio frame, sums
// the enabled voices serially, scales by a volume shift, saturates and hands off.
module voice_mixer #(
    parameter int NUM_VOICES = 8,
    parameter int SAMPLE_DIV = 1042
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [32*NUM_VOICES-1:0]     voice_in,
    input  logic [NUM_VOICES-1:0]        voice_en,
    input  logic [2:0]                   volume,
    input  logic                         audio_out_allowed,
    output logic signed [31:0]           left_channel_audio_out,
    output logic signed [31:0]           right_channel_audio_out,
    output logic                         write_audio_out,
    output logic                         clear_audio_out_memory,
    output logic [15:0]                  overrun_count,
    output logic                         busy
);

    localparam int AW = 32 + $clog2(NUM_VOICES);
    localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    typedef enum logic [2:0] {IDLE, ACCUM, SCALE, WAIT, WRITE} state_t;

    state_t                     state, state_d;
    logic [CW-1:0]              cnt;
    logic                       tick;
    logic [32*NUM_VOICES-1:0]   snap_voice;
    logic [NUM_VOICES-1:0]      snap_en;
    logic [2:0]                 snap_vol;
    logic [IW-1:0]              idx;
    logic signed [AW-1:0]       acc;
    logic signed [31:0]         cur_voice;
    logic signed [AW-1:0]       cur_term;
    logic signed [AW-1:0]       scaled;
    logic                       en_any;

    // Anything whose bits above 30 are not all copies of the sign is out of range.
    function automatic logic signed [31:0] sat32(input logic signed [AW-1:0] s);
        logic [AW-32:0] top;
        top = s[AW-1:31];
        if ((&top) || !(|top))
            return s[31:0];
        else if (s[AW-1])
            return 32'sh8000_0000;
        else
            return 32'sh7FFF_FFFF;
    endfunction

    assign tick = (cnt == CW'(SAMPLE_DIV - 1));
    assign busy = (state != IDLE);

    always_comb begin
        cur_voice = snap_voice[idx*32 +: 32];
        cur_term  = '0;
        if (snap_en[idx])
            cur_term = cur_voice;
        scaled = acc >>> snap_vol;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (tick) state_d = ACCUM;
            ACCUM:   if (idx == IW'(NUM_VOICES - 1)) state_d = SCALE;
            SCALE:   state_d = WAIT;
            WAIT:    if (audio_out_allowed) state_d = WRITE;
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state                   <= IDLE;
            cnt                     <= '0;
            snap_voice              <= '0;
            snap_en                 <= '0;
            snap_vol                <= '0;
            idx                     <= '0;
            acc                     <= '0;
            left_channel_audio_out  <= '0;
            right_channel_audio_out <= '0;
            write_audio_out         <= 1'b0;
            clear_audio_out_memory  <= 1'b0;
            en_any                  <= 1'b0;
            overrun_count           <= '0;
        end else begin
            state                  <= state_d;
            cnt                    <= tick ? '0 : cnt + CW'(1);
            write_audio_out        <= (state == WRITE);
            en_any                 <= |voice_en;
            clear_audio_out_memory <= en_any & ~(|voice_en);
            // Frames are never queued: a tick that finds the path busy is just counted.
            if (tick && (state != IDLE) && (overrun_count != 16'hFFFF))
                overrun_count <= overrun_count + 16'd1;
            case (state)
                IDLE: if (tick) begin
                    snap_voice <= voice_in;
                    snap_en    <= voice_en;
                    snap_vol   <= volume;
                    acc        <= '0;
                    idx        <= '0;
                end
                ACCUM: begin
                    acc <= acc + cur_term;
                    idx <= idx + IW'(1);
                end
                SCALE: begin
                    left_channel_audio_out  <= sat32(scaled);
                    right_channel_audio_out <= sat32(scaled);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_voice_mixer.sv
// Directed bench for voice_mixer: frame timing, mixing, saturation, backpressure,
// mid-frame reset and the clear pulse.
module tb_voice_mixer;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [255:0]       voice_in = '0;
    logic [7:0]         voice_en = '0;
    logic [2:0]         volume = '0;
    logic               audio_out_allowed = 1'b1;
    logic signed [31:0] left, right;
    logic               write, clear;
    logic [15:0]        overrun;
    logic               busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_w = 0;

    voice_mixer #(.NUM_VOICES(8), .SAMPLE_DIV(1042)) dut (
        .clock(clk),
        .reset(reset),
        .voice_in(voice_in),
        .voice_en(voice_en),
        .volume(volume),
        .audio_out_allowed(audio_out_allowed),
        .left_channel_audio_out(left),
        .right_channel_audio_out(right),
        .write_audio_out(write),
        .clear_audio_out_memory(clear),
        .overrun_count(overrun),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic do_reset(output int c0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        c0 = cyc;
    endtask

    task automatic wait_write(input int maxc, output int at);
        at = -1;
        for (int i = 0; i < maxc && at < 0; i++) begin
            @(negedge clk);
            if (write) at = cyc;
        end
    endtask

    task automatic test_reset();
        int c0;
        voice_in = '0;
        voice_in[31:0] = 32'sd300000000;
        voice_en = 8'h01;
        volume = 3'd0;
        audio_out_allowed = 1'b1;
        do_reset(c0);
        last_w = c0;
        checks++; if (left !== 32'sd0) begin errors++; $display("FAIL reset_left got %0d want 0", left); end
        checks++; if (right !== 32'sd0) begin errors++; $display("FAIL reset_right got %0d want 0", right); end
        checks++; if (write !== 1'b0) begin errors++; $display("FAIL reset_write got %b want 0", write); end
        checks++; if (clear !== 1'b0) begin errors++; $display("FAIL reset_clear got %b want 0", clear); end
        checks++; if (overrun !== 16'd0) begin errors++; $display("FAIL reset_overrun got %0d want 0", overrun); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    endtask

    task automatic test_single_voice();
        int at, at2;
        wait_write(1100, at);
        checks++; if (at - last_w !== 1053) begin errors++; $display("FAIL first_write_latency got %0d want 1053", at - last_w); end
        checks++; if (left !== 32'sd300000000) begin errors++; $display("FAIL single_left got %0d want 300000000", left); end
        checks++; if (right !== 32'sd300000000) begin errors++; $display("FAIL single_right got %0d want 300000000", right); end
        @(negedge clk);
        checks++; if (write !== 1'b0) begin errors++; $display("FAIL write_one_cycle got %b want 0", write); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_after_write got %b want 0", busy); end
        wait_write(1100, at2);
        checks++; if (at2 - at !== 1042) begin errors++; $display("FAIL write_period got %0d want 1042", at2 - at); end
        last_w = at2;
    endtask

    task automatic test_saturation();
        logic signed [31:0] vals [6] = '{32'sh7FFFFFFF, 32'sh80000000, 32'sh7FFFFFFF,
                                         32'sd300000000, -32'sd300000001, 32'sh80000000};
        logic [7:0]         ens  [6] = '{8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h01, 8'hFF};
        logic [2:0]         vols [6] = '{3'd0, 3'd0, 3'd3, 3'd1, 3'd1, 3'd3};
        logic signed [31:0] exps [6] = '{32'sh7FFFFFFF, 32'sh80000000, 32'sh7FFFFFFF,
                                         32'sd150000000, -32'sd150000001, 32'sh80000000};
        int at;
        for (int k = 0; k < 6; k++) begin
            voice_in = {8{vals[k]}};
            voice_en = ens[k];
            volume = vols[k];
            wait_write(1100, at);
            checks++; if (at - last_w !== 1042) begin errors++; $display("FAIL sat_period[%0d] got %0d want 1042", k, at - last_w); end
            checks++; if (left !== exps[k]) begin errors++; $display("FAIL sat_left[%0d] got %0d want %0d", k, left, exps[k]); end
            checks++; if (right !== exps[k]) begin errors++; $display("FAIL sat_right[%0d] got %0d want %0d", k, right, exps[k]); end
            last_w = at;
        end
    endtask

    task automatic test_mix_snapshot();
        int at, t;
        voice_in = '0;
        voice_in[31:0]  = 32'sd300000000;
        voice_in[63:32] = -32'sd100000000;
        voice_in[95:64] = 32'sd50000000;
        voice_en = 8'b011;
        volume = 3'd0;
        wait_write(1100, at);
        checks++; if (left !== 32'sd200000000) begin errors++; $display("FAIL mix_left got %0d want 200000000", left); end
        last_w = at;
        t = last_w + 1031;
        while (cyc < t + 2) @(negedge clk);
        voice_in = {8{32'sd5}};
        wait_write(1100, at);
        checks++; if (at - last_w !== 1042) begin errors++; $display("FAIL snap_period got %0d want 1042", at - last_w); end
        checks++; if (left !== 32'sd200000000) begin errors++; $display("FAIL snap_left got %0d want 200000000", left); end
        last_w = at;
    endtask

    task automatic test_backpressure();
        int at, t, nw;
        voice_in = '0;
        voice_in[31:0] = 32'sd123456789;
        voice_en = 8'h01;
        volume = 3'd0;
        audio_out_allowed = 1'b0;
        t = last_w + 1031;
        nw = 0;
        while (cyc < t + 2500) begin
            @(negedge clk);
            if (write) nw++;
            if (cyc == t + 20) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_in_wait got %b want 1", busy); end
            end
        end
        checks++; if (nw !== 0) begin errors++; $display("FAIL stalled_writes got %0d want 0", nw); end
        checks++; if (overrun !== 16'd2) begin errors++; $display("FAIL overrun_count got %0d want 2", overrun); end
        audio_out_allowed = 1'b1;
        wait_write(20, at);
        checks++; if (at - t !== 2502) begin errors++; $display("FAIL release_write got %0d want 2502", at - t); end
        checks++; if (left !== 32'sd123456789) begin errors++; $display("FAIL release_left got %0d want 123456789", left); end
        nw = 0;
        while (cyc < t + 3126) begin
            @(negedge clk);
            if (write) nw++;
        end
        checks++; if (nw !== 0) begin errors++; $display("FAIL extra_writes got %0d want 0", nw); end
        wait_write(40, at);
        checks++; if (at - t !== 3137) begin errors++; $display("FAIL resume_write got %0d want 3137", at - t); end
        checks++; if (overrun !== 16'd2) begin errors++; $display("FAIL overrun_hold got %0d want 2", overrun); end
        last_w = at;
    endtask

    task automatic test_reset_mid();
        int at, t, c0;
        t = last_w + 1031;
        while (cyc < t + 3) @(negedge clk);
        do_reset(c0);
        checks++; if (left !== 32'sd0) begin errors++; $display("FAIL midrst_left got %0d want 0", left); end
        checks++; if (right !== 32'sd0) begin errors++; $display("FAIL midrst_right got %0d want 0", right); end
        checks++; if (overrun !== 16'd0) begin errors++; $display("FAIL midrst_overrun got %0d want 0", overrun); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
        wait_write(1100, at);
        checks++; if (at - c0 !== 1053) begin errors++; $display("FAIL midrst_next_write got %0d want 1053", at - c0); end
        checks++; if (left !== 32'sd123456789) begin errors++; $display("FAIL midrst_left_after got %0d want 123456789", left); end
        last_w = at;
    endtask

    task automatic test_clear();
        int n;
        logic first;
        voice_en = 8'h01;
        repeat (2) @(negedge clk);
        voice_en = 8'h00;
        n = 0;
        first = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) first = clear;
            if (clear) n++;
        end
        checks++; if (first !== 1'b1) begin errors++; $display("FAIL clear_timing got %b want 1", first); end
        checks++; if (n !== 1) begin errors++; $display("FAIL clear_width got %0d want 1", n); end
        voice_en = 8'h04;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (clear) n++;
        end
        checks++; if (n !== 0) begin errors++; $display("FAIL clear_on_rise got %0d want 0", n); end
    endtask

    initial begin
        test_reset();
        test_single_voice();
        test_saturation();
        test_mix_snapshot();
        test_backpressure();
        test_reset_mid();
        test_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
